// File: rtl/rom_arbiter_pkg.sv
// Shared types and ROM geometry for the boot-ROM arbiter.
// The response register payload and the address range check live here.
package rom_arbiter_pkg;

    localparam int unsigned NPORTS   = 2;
    localparam int unsigned ROM_BITS = 12;
    localparam int unsigned ROM_AW   = ROM_BITS - 2;

    localparam logic [31:0] ROM_BASE_ADDR = 32'h0001_0000;
    localparam logic [31:0] ROM_END_ADDR  = ROM_BASE_ADDR + 32'(1 << ROM_BITS);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rom_rsp_t;

    // Word-aligned and inside [ROM_BASE_ADDR, ROM_END_ADDR), unsigned compare.
    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr >= ROM_BASE_ADDR) && (addr < ROM_END_ADDR) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Per-port request/response handshake bundle between the requesters and the arbiter.
interface rom_arbiter_if;
    import rom_arbiter_pkg::*;

    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS-1:0][31:0]  req_addr;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS-1:0]        rsp_valid;
    logic [NPORTS-1:0][31:0]  rsp_data;
    logic [NPORTS-1:0]        rsp_err;
    logic [NPORTS-1:0]        rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin picker; owns the most-recently-granted index.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic last;

    // On a conflict the port that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (eligible == 2'b11) grant = last ? 2'b01 : 2'b10;
            else                   grant = eligible;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last <= 1'b1;
        else if (|grant)  last <= grant[1];
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the combinational boot ROM between fetch (port 0) and load (port 1),
// one access per cycle, with a single-entry response register per port.
module rom_arbiter
    import rom_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rom_arbiter_if.slave      bus,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data
);

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] grant;
    logic [NPORTS-1:0] valid_q;
    rom_rsp_t          rsp_q [NPORTS];
    logic [31:0]       gnt_addr;
    logic              gnt_ok;
    rom_rsp_t          new_rsp;

    // A slot draining this cycle counts as free, giving 1/cycle per port.
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            eligible[p] = bus.req_valid[p] & (~valid_q[p] | bus.rsp_ready[p]);
        end
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .grant    (grant)
    );

    // Failing accesses leave the ROM unaddressed but still use the cycle.
    always_comb begin
        gnt_addr     = bus.req_addr[grant[1]];
        gnt_ok       = addr_ok(gnt_addr);
        rom_addr     = '0;
        if ((|grant) && gnt_ok) rom_addr = gnt_addr[ROM_BITS-1:2];
        new_rsp.err  = ~gnt_ok;
        new_rsp.data = gnt_ok ? rom_data : 32'h0;
    end

    for (genvar p = 0; p < int'(NPORTS); p++) begin : g_rsp
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q[p] <= 1'b0;
                rsp_q[p]   <= '0;
            end else if (grant[p]) begin
                valid_q[p] <= 1'b1;
                rsp_q[p]   <= new_rsp;
            end else if (bus.rsp_ready[p]) begin
                valid_q[p] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = valid_q;
        for (int p = 0; p < int'(NPORTS); p++) begin
            bus.rsp_data[p] = rsp_q[p].data;
            bus.rsp_err[p]  = rsp_q[p].err;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-level model of the two response slots.
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;

    logic              clk;
    logic              rst;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [31:0]       mem [1 << ROM_AW];

    int n_cmp = 0;
    int n_bad = 0;

    rom_arbiter_if bus ();

    rom_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    assign rom_data = mem[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit in_rom(input logic [31:0] a);
        return (a >= ROM_BASE_ADDR) && (a < ROM_END_ADDR) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] word_idx(input logic [31:0] a);
        return (a - ROM_BASE_ADDR) / 4;
    endfunction

    // Model: each port holds at most one pending response; pref is the port
    // that wins the next conflict.
    bit          m_full [2];
    bit          m_err  [2];
    logic [31:0] m_data [2];
    int          pref;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_full[p] = 0;
            m_err[p]  = 0;
            m_data[p] = 0;
        end
        pref = 0;
    endtask

    always begin : compare
        int          g;
        bit          elig [2];
        logic [31:0] gaddr;
        logic [1:0]  exp_ready;
        logic [1:0]  drn;
        @(negedge clk);
        g = -1;
        gaddr = 0;
        drn = bus.rsp_ready;
        if (rst) begin
            model_reset();
            chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("rst_rsp_data0", 64'(bus.rsp_data[0]), 64'(0));
            chk("rst_rsp_data1", 64'(bus.rsp_data[1]), 64'(0));
            chk("rst_rsp_err",   64'(bus.rsp_err), 64'(0));
        end else begin
            for (int p = 0; p < 2; p++) elig[p] = bus.req_valid[p] && (!m_full[p] || drn[p]);
            if (elig[0] && elig[1]) g = pref;
            else if (elig[0])       g = 0;
            else if (elig[1])       g = 1;
            exp_ready = 2'b00;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                gaddr = bus.req_addr[g];
            end
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rom_addr", 64'(rom_addr),
                64'((g >= 0 && in_rom(gaddr)) ? word_idx(gaddr) : 32'h0));
            for (int p = 0; p < 2; p++) begin
                chk("rsp_valid", 64'(bus.rsp_valid[p]), 64'(m_full[p]));
                if (m_full[p]) begin
                    chk("rsp_data", 64'(bus.rsp_data[p]), 64'(m_data[p]));
                    chk("rsp_err",  64'(bus.rsp_err[p]),  64'(m_err[p]));
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (p == g) begin
                    m_full[p] = 1;
                    m_err[p]  = !in_rom(gaddr);
                    m_data[p] = in_rom(gaddr) ? mem[word_idx(gaddr)] : 32'h0;
                end else if (m_full[p] && drn[p]) begin
                    m_full[p] = 0;
                end
            end
            if (g >= 0) pref = 1 - g;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 11);
        case (r)
            0:       return ROM_END_ADDR + 32'($urandom_range(0, 3) * 4);
            1:       return ROM_BASE_ADDR - 32'h4;
            2:       return ROM_BASE_ADDR + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(1, 3));
            3:       return ROM_END_ADDR - 32'h4;
            4:       return ROM_BASE_ADDR;
            default: return ROM_BASE_ADDR + 32'($urandom_range(0, 1023) * 4);
        endcase
    endfunction

    initial begin : stim
        logic [31:0] held;
        for (int i = 0; i < (1 << ROM_AW); i++) mem[i] = $urandom;
        bus.req_valid = 2'b00;
        bus.req_addr  = '0;
        bus.rsp_ready = 2'b00;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset held with both ports requesting
        bus.req_valid   = 2'b11;
        bus.req_addr[0] = ROM_BASE_ADDR;
        bus.req_addr[1] = ROM_BASE_ADDR + 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("t1_req_ready", 64'(bus.req_ready), 64'(0));
            chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("t1_rsp_data0", 64'(bus.rsp_data[0]), 64'(0));
        end
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        tick();

        // Single fetch of word 2
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = ROM_BASE_ADDR + 32'h8;
        #2;
        chk("t2_req_ready", 64'(bus.req_ready), 64'(2'b01));
        chk("t2_rom_addr",  64'(rom_addr), 64'(2));
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
        chk("t2_rsp_data",  64'(bus.rsp_data[0]), 64'(mem[2]));
        chk("t2_rsp_err",   64'(bus.rsp_err[0]), 64'(0));
        tick();

        // Continuous contention after reset alternates 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bus.req_addr[0] = ROM_BASE_ADDR + 32'(4 * k);
            bus.req_addr[1] = ROM_BASE_ADDR + 32'h100 + 32'(4 * k);
            #2;
            chk("t3_grant", 64'(bus.req_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            if (k == 1) chk("t3_data0", 64'(bus.rsp_data[0]), 64'(mem[0]));
            if (k == 2) chk("t3_data1", 64'(bus.rsp_data[1]), 64'(mem[64 + 1]));
            tick();
        end
        bus.req_valid = 2'b00;
        tick();

        // Out-of-range and misaligned loads
        bus.req_valid   = 2'b10;
        bus.req_addr[1] = ROM_END_ADDR;
        #2;
        chk("t4_ready_end", 64'(bus.req_ready), 64'(2'b10));
        chk("t4_rom_addr",  64'(rom_addr), 64'(0));
        tick();
        bus.req_addr[1] = ROM_BASE_ADDR + 32'h2;
        #2;
        chk("t4_err_end",  64'(bus.rsp_err[1]), 64'(1));
        chk("t4_data_end", 64'(bus.rsp_data[1]), 64'(0));
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("t4_err_mis",  64'(bus.rsp_err[1]), 64'(1));
        chk("t4_data_mis", 64'(bus.rsp_data[1]), 64'(0));
        tick();

        // Backpressure on fetch while load keeps flowing
        bus.rsp_ready   = 2'b10;
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = ROM_BASE_ADDR + 32'h40;
        #2;
        chk("t5_first", 64'(bus.req_ready), 64'(2'b01));
        tick();
        held = mem[16];
        bus.req_valid   = 2'b11;
        bus.req_addr[0] = ROM_BASE_ADDR + 32'h80;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[1] = ROM_BASE_ADDR + 32'h200 + 32'(4 * i);
            #2;
            chk("t5_blocked",   64'(bus.req_ready), 64'(2'b10));
            chk("t5_held_data", 64'(bus.rsp_data[0]), 64'(held));
            tick();
        end
        bus.rsp_ready = 2'b11;
        #2;
        chk("t5_release", 64'(bus.req_ready), 64'(2'b01));
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("t5_valid_kept", 64'(bus.rsp_valid[0]), 64'(1));
        chk("t5_new_data",   64'(bus.rsp_data[0]), 64'(mem[32]));
        tick();
        tick();

        // Async reset with both slots full
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b11;
        tick();
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("t6_both_full", 64'(bus.rsp_valid), 64'(2'b11));
        #1 rst = 1'b1;
        #1;
        chk("t6_async_clear", 64'(bus.rsp_valid), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        #2;
        chk("t6_first_conflict", 64'(bus.req_ready), 64'(2'b01));
        tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid   = 2'($urandom_range(0, 3));
            bus.req_addr[0] = rand_addr();
            bus.req_addr[1] = rand_addr();
            bus.rsp_ready[0] = ($urandom_range(0, 3) != 0);
            bus.rsp_ready[1] = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
